// File: rtl/control_sequencer.sv
// Fetch/latch/decode/immediate/execute controller for an 8-bit instruction stream.
// Owns the PC and drives the register-file strobes, ALU opcode and immediate path.
module control_sequencer #(
    parameter int                    ADDR_WIDTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RUN,
    input  logic [7:0]            PROG_DATA,
    input  logic                  ZERO_FLAG,
    output logic [ADDR_WIDTH-1:0] PROG_ADDR,
    output logic [1:0]            DST_SELECTION,
    output logic [1:0]            SRC_SELECTION,
    output logic                  LOAD_DST,
    output logic                  LOAD_FLAGS,
    output logic [2:0]            ALU_OP,
    output logic                  IMM_SEL,
    output logic [7:0]            IMM_VALUE,
    output logic                  HALTED
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_LATCH  = 3'd1,
        S_DECODE = 3'd2,
        S_IMM    = 3'd3,
        S_EXEC   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [7:0]              ir_q, ir_d;
    logic [7:0]              imm_q, imm_d;
    logic [3:0]              opcode;
    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic [ADDR_WIDTH-1:0]   jmp_target;

    assign opcode     = ir_q[7:4];
    assign pc_inc     = pc_q + ADDR_WIDTH'(1);
    // The cast zero-extends for wide PCs and keeps the low bits for narrow ones.
    assign jmp_target = ADDR_WIDTH'(imm_q);

    assign PROG_ADDR     = pc_q;
    assign DST_SELECTION = ir_q[3:2];
    assign SRC_SELECTION = ir_q[1:0];
    assign IMM_VALUE     = imm_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_VECTOR;
            ir_q    <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        imm_d      = imm_q;
        LOAD_DST   = 1'b0;
        LOAD_FLAGS = 1'b0;
        ALU_OP     = 3'b000;
        IMM_SEL    = 1'b0;
        HALTED     = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (RUN) state_d = S_LATCH;
            end
            S_LATCH: begin
                ir_d    = PROG_DATA;
                pc_d    = pc_inc;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // PC already points at the immediate byte, so it arrives in S_IMM.
                if (opcode == OP_LDI || opcode == OP_JMP || opcode == OP_JZ) state_d = S_IMM;
                else state_d = S_EXEC;
            end
            S_IMM: begin
                imm_d   = PROG_DATA;
                pc_d    = pc_inc;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode)
                    OP_MOV: LOAD_DST = 1'b1;
                    OP_ADD: begin LOAD_DST = 1'b1; LOAD_FLAGS = 1'b1; ALU_OP = 3'b001; end
                    OP_SUB: begin LOAD_DST = 1'b1; LOAD_FLAGS = 1'b1; ALU_OP = 3'b010; end
                    OP_AND: begin LOAD_DST = 1'b1; LOAD_FLAGS = 1'b1; ALU_OP = 3'b011; end
                    OP_OR:  begin LOAD_DST = 1'b1; LOAD_FLAGS = 1'b1; ALU_OP = 3'b100; end
                    OP_LDI: begin LOAD_DST = 1'b1; IMM_SEL = 1'b1; end
                    OP_JMP: pc_d = jmp_target;
                    OP_JZ:  if (ZERO_FLAG) pc_d = jmp_target;
                    OP_HALT: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_HALT: begin
                HALTED = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a vector table of single instructions plus
// hand-written reset, halt and narrow-PC wrap/stall sequences.
module tb_control_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RUN = 1'b0;
    logic       ZERO_FLAG = 1'b0;
    logic [7:0] PROG_DATA;
    logic [7:0] PROG_ADDR;
    logic [1:0] DST_SELECTION, SRC_SELECTION;
    logic       LOAD_DST, LOAD_FLAGS, IMM_SEL, HALTED;
    logic [2:0] ALU_OP;
    logic [7:0] IMM_VALUE;

    logic       RUN4 = 1'b0;
    logic [7:0] PROG_DATA4;
    logic [3:0] PROG_ADDR4;
    logic [1:0] dst4, src4;
    logic       ld4, lf4, isel4, halted4;
    logic [2:0] alu4;
    logic [7:0] imm4;

    logic [7:0] mem  [256];
    logic [7:0] mem4 [16];

    int n_total = 0;
    int n_pass  = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        PROG_DATA  <= mem[PROG_ADDR];
        PROG_DATA4 <= mem4[PROG_ADDR4];
    end

    control_sequencer #(.ADDR_WIDTH(8), .RESET_VECTOR(8'h00)) dut (
        .CLK(CLK), .RST(RST), .RUN(RUN), .PROG_DATA(PROG_DATA), .ZERO_FLAG(ZERO_FLAG),
        .PROG_ADDR(PROG_ADDR), .DST_SELECTION(DST_SELECTION), .SRC_SELECTION(SRC_SELECTION),
        .LOAD_DST(LOAD_DST), .LOAD_FLAGS(LOAD_FLAGS), .ALU_OP(ALU_OP), .IMM_SEL(IMM_SEL),
        .IMM_VALUE(IMM_VALUE), .HALTED(HALTED)
    );

    control_sequencer #(.ADDR_WIDTH(4), .RESET_VECTOR(4'h0)) dut4 (
        .CLK(CLK), .RST(RST), .RUN(RUN4), .PROG_DATA(PROG_DATA4), .ZERO_FLAG(1'b0),
        .PROG_ADDR(PROG_ADDR4), .DST_SELECTION(dst4), .SRC_SELECTION(src4),
        .LOAD_DST(ld4), .LOAD_FLAGS(lf4), .ALU_OP(alu4), .IMM_SEL(isel4),
        .IMM_VALUE(imm4), .HALTED(halted4)
    );

    // exec_out = {LOAD_DST, LOAD_FLAGS, ALU_OP[2:0], IMM_SEL, DST[1:0], SRC[1:0]} in S_EXEC
    typedef struct {
        string      name;
        logic [7:0] b0;
        logic [7:0] b1;
        logic       zf;
        int         len;
        logic [9:0] exec_out;
        logic [7:0] imm;
        logic [7:0] next_pc;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic do_reset();
        RST = 1'b1; RUN = 1'b0; RUN4 = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1);
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = b0;
        mem[1] = b1;
    endtask

    // Starts one instruction with a single-cycle RUN pulse, then lets it stall in S_FETCH.
    task automatic run_vec(input vec_t v);
        int ld_cnt, bad, unstable;
        ld_cnt = 0; bad = 0; unstable = 0;
        load_prog(v.b0, v.b1);
        ZERO_FLAG = v.zf;
        do_reset();
        RUN = 1'b1;
        for (int c = 1; c <= v.len; c++) begin
            if (c == v.len) begin
                check($sformatf("%s_exec", v.name),
                      {22'd0, LOAD_DST, LOAD_FLAGS, ALU_OP, IMM_SEL, DST_SELECTION, SRC_SELECTION},
                      {22'd0, v.exec_out});
                check($sformatf("%s_imm", v.name), {24'd0, IMM_VALUE}, {24'd0, v.imm});
            end else if (LOAD_DST || LOAD_FLAGS || IMM_SEL || ALU_OP != 3'd0) begin
                bad++;
            end
            if (LOAD_DST) ld_cnt++;
            if (c >= 3 && {DST_SELECTION, SRC_SELECTION} !== v.exec_out[3:0]) unstable++;
            @(posedge CLK);
            #1 RUN = 1'b0;
            @(negedge CLK);
        end
        check($sformatf("%s_ld_pulses", v.name), ld_cnt, {31'd0, v.exec_out[9]});
        check($sformatf("%s_early_strobes", v.name), bad, 0);
        check($sformatf("%s_sel_stable", v.name), unstable, 0);
        check($sformatf("%s_next_pc", v.name), {24'd0, PROG_ADDR}, {24'd0, v.next_pc});
        repeat (3) @(negedge CLK);
        check($sformatf("%s_stall", v.name), {23'd0, LOAD_DST, PROG_ADDR}, {24'd0, v.next_pc});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int herr;
        vecs[0]  = '{"mov",   8'h19, 8'h00, 1'b0, 4, {1'b1, 1'b0, 3'd0, 1'b0, 2'd2, 2'd1}, 8'h00, 8'h01};
        vecs[1]  = '{"add",   8'h27, 8'h00, 1'b0, 4, {1'b1, 1'b1, 3'd1, 1'b0, 2'd1, 2'd3}, 8'h00, 8'h01};
        vecs[2]  = '{"sub",   8'h3E, 8'h00, 1'b0, 4, {1'b1, 1'b1, 3'd2, 1'b0, 2'd3, 2'd2}, 8'h00, 8'h01};
        vecs[3]  = '{"and",   8'h41, 8'h00, 1'b0, 4, {1'b1, 1'b1, 3'd3, 1'b0, 2'd0, 2'd1}, 8'h00, 8'h01};
        vecs[4]  = '{"or",    8'h5B, 8'h00, 1'b0, 4, {1'b1, 1'b1, 3'd4, 1'b0, 2'd2, 2'd3}, 8'h00, 8'h01};
        vecs[5]  = '{"nop",   8'h0F, 8'h00, 1'b0, 4, {1'b0, 1'b0, 3'd0, 1'b0, 2'd3, 2'd3}, 8'h00, 8'h01};
        vecs[6]  = '{"op_a",  8'hA5, 8'h00, 1'b1, 4, {1'b0, 1'b0, 3'd0, 1'b0, 2'd1, 2'd1}, 8'h00, 8'h01};
        vecs[7]  = '{"ldi",   8'h6C, 8'hA5, 1'b0, 5, {1'b1, 1'b0, 3'd0, 1'b1, 2'd3, 2'd0}, 8'hA5, 8'h02};
        vecs[8]  = '{"jmp",   8'h70, 8'h33, 1'b0, 5, {1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0}, 8'h33, 8'h33};
        vecs[9]  = '{"jz_nt", 8'h80, 8'h10, 1'b0, 5, {1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0}, 8'h10, 8'h02};
        vecs[10] = '{"jz_t",  8'h80, 8'h10, 1'b1, 5, {1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0}, 8'h10, 8'h10};
        vecs[11] = '{"jmp_ff",8'h75, 8'hFF, 1'b0, 5, {1'b0, 1'b0, 3'd0, 1'b0, 2'd1, 2'd1}, 8'hFF, 8'hFF};

        for (int i = 0; i < 16; i++) mem4[i] = 8'h00;
        load_prog(8'h00, 8'h00);
        do_reset();
        check("reset_state",
              {13'd0, PROG_ADDR, HALTED, LOAD_DST, LOAD_FLAGS, IMM_SEL, ALU_OP, IMM_VALUE},
              32'd0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Reset asserted in the middle of ADD's execute cycle.
        load_prog(8'h27, 8'h00);
        ZERO_FLAG = 1'b0;
        do_reset();
        RUN = 1'b1;
        @(posedge CLK);
        #1 RUN = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_pre_ld", {31'd0, LOAD_DST}, 32'd1);
        #1 RST = 1'b1;
        #1 check("rst_async",
                 {19'd0, LOAD_DST, LOAD_FLAGS, PROG_ADDR, HALTED, DST_SELECTION},
                 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // HALT with RUN held high: nothing moves for 20 cycles.
        load_prog(8'hF0, 8'h00);
        do_reset();
        RUN = 1'b1;
        herr = 0;
        for (int c = 1; c <= 25; c++) begin
            if (c == 5) check("halt_c5", {31'd0, HALTED}, 32'd1);
            if (HALTED !== (c >= 5)) herr++;
            if (c >= 5 && (PROG_ADDR !== 8'h01 || LOAD_DST || LOAD_FLAGS || IMM_SEL || ALU_OP != 3'd0))
                herr++;
            @(negedge CLK);
        end
        check("halt_frozen", herr, 0);
        RUN = 1'b0;
        #1 RST = 1'b1;
        #1 check("halt_rst", {31'd0, HALTED}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Narrow PC: JMP 0xFF truncates to 0xF, NOP there wraps the PC to 0, then stall.
        mem4[0]  = 8'h70;
        mem4[1]  = 8'hFF;
        mem4[15] = 8'h00;
        do_reset();
        RUN4 = 1'b1;
        @(posedge CLK);
        #1 RUN4 = 1'b0;
        repeat (5) @(negedge CLK);
        check("aw4_jmp_trunc", {28'd0, PROG_ADDR4}, 32'hF);
        RUN4 = 1'b1;
        @(posedge CLK);
        #1 RUN4 = 1'b0;
        repeat (4) @(negedge CLK);
        check("aw4_wrap", {28'd0, PROG_ADDR4}, 32'h0);
        herr = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (PROG_ADDR4 !== 4'h0 || ld4 || lf4 || isel4) herr++;
        end
        check("aw4_stall", herr, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
